// File: rtl/master_tiled_multip_control.sv
// Tile sequencer for a full W x D multiply on the systolic array.
// Walks (r,k,c) tiles and handshakes each phase with the downstream controllers.
module master_tiled_multip_control #(
  parameter int SYS_ARR_WIDTH  = 16,
  parameter int SYS_ARR_HEIGHT = 16,
  parameter int MAX_OUT_ROWS   = 128,
  parameter int MAX_OUT_COLS   = 128,
  parameter int MAX_INTERMED   = 128,
  parameter int ADDR_WIDTH     = 16,
  localparam int MAX_RC = (MAX_OUT_ROWS > MAX_OUT_COLS) ?
                          MAX_OUT_ROWS : MAX_OUT_COLS,
  localparam int MAX_D  = (MAX_RC > MAX_INTERMED) ? MAX_RC : MAX_INTERMED,
  localparam int DW     = $clog2(MAX_D) + 1,
  localparam int RL     = $clog2(MAX_OUT_ROWS / SYS_ARR_HEIGHT),
  localparam int CL     = $clog2(MAX_OUT_COLS / SYS_ARR_WIDTH),
  localparam int RW     = (RL > 1) ? RL : 1,
  localparam int CW     = (CL > 1) ? CL : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic [DW-1:0]         num_row_weight_mat,
  input  logic [DW-1:0]         intermed_dim,
  input  logic [DW-1:0]         num_col_in_mat,
  input  logic [ADDR_WIDTH-1:0] base_weight,
  input  logic [ADDR_WIDTH-1:0] base_data,
  input  logic                  weight_mem_fifo_done,
  input  logic                  weight_fifo_arr_done,
  input  logic                  data_mem_calc_done,
  output logic                  weight_mem_fifo_en,
  output logic                  weight_fifo_arr_en,
  output logic                  data_mem_calc_en,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [RW-1:0]         accum_table_submat_row_out,
  output logic [CW-1:0]         accum_table_submat_col_out,
  output logic                  accum_en,
  output logic                  busy,
  output logic                  done
);

  // one spare bit so the ceil() rounding of an oversized dimension cannot wrap
  localparam int TW = DW + 1;
  localparam logic [TW-1:0] ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    W_MEM,
    W_ARR,
    D_CALC,
    ADVANCE,
    FINISH
  } state_t;

  state_t state, state_n;

  logic [TW-1:0] rt, kt, ct;
  logic [TW-1:0] rt_n, kt_n, ct_n;
  logic [TW-1:0] r, k, c;
  logic [TW-1:0] r_n, k_n, c_n;
  logic [TW-1:0] rt_in, kt_in, ct_in;
  logic [ADDR_WIDTH-1:0] bw, bd, bw_n, bd_n;
  logic start, dims_zero;
  logic r_last, k_last, c_last;

  assign start = (state == IDLE) && active;

  assign dims_zero = (num_row_weight_mat == '0) ||
                     (intermed_dim == '0) ||
                     (num_col_in_mat == '0);

  assign rt_in = (TW'(num_row_weight_mat) + TW'(SYS_ARR_HEIGHT - 1)) /
                 TW'(SYS_ARR_HEIGHT);
  assign kt_in = (TW'(intermed_dim) + TW'(SYS_ARR_HEIGHT - 1)) /
                 TW'(SYS_ARR_HEIGHT);
  assign ct_in = (TW'(num_col_in_mat) + TW'(SYS_ARR_WIDTH - 1)) /
                 TW'(SYS_ARR_WIDTH);

  assign r_last = (r == rt - ONE);
  assign k_last = (k == kt - ONE);
  assign c_last = (c == ct - ONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (active) state_n = dims_zero ? FINISH : W_MEM;
      end
      W_MEM: begin
        if (weight_mem_fifo_done) state_n = W_ARR;
      end
      W_ARR: begin
        if (weight_fifo_arr_done) state_n = D_CALC;
      end
      D_CALC: begin
        if (data_mem_calc_done) state_n = ADVANCE;
      end
      ADVANCE: begin
        if (!c_last)                 state_n = D_CALC;
        else if (!k_last || !r_last) state_n = W_MEM;
        else                         state_n = FINISH;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // next tile position; addresses are registered from these so they are
  // already valid in the first cycle of the enable they belong to
  always_comb begin
    rt_n = rt;
    kt_n = kt;
    ct_n = ct;
    r_n  = r;
    k_n  = k;
    c_n  = c;
    bw_n = bw;
    bd_n = bd;
    if (start) begin
      rt_n = rt_in;
      kt_n = kt_in;
      ct_n = ct_in;
      r_n  = '0;
      k_n  = '0;
      c_n  = '0;
      bw_n = base_weight;
      bd_n = base_data;
    end else if (state == ADVANCE) begin
      if (!c_last) begin
        c_n = c + ONE;
      end else if (!k_last || !r_last) begin
        c_n = '0;
        if (!k_last) begin
          k_n = k + ONE;
        end else begin
          k_n = '0;
          r_n = r + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                      <= IDLE;
      rt                         <= '0;
      kt                         <= '0;
      ct                         <= '0;
      r                          <= '0;
      k                          <= '0;
      c                          <= '0;
      bw                         <= '0;
      bd                         <= '0;
      weight_addr                <= '0;
      data_addr                  <= '0;
      accum_table_submat_row_out <= '0;
      accum_table_submat_col_out <= '0;
      accum_en                   <= 1'b0;
    end else begin
      state       <= state_n;
      rt          <= rt_n;
      kt          <= kt_n;
      ct          <= ct_n;
      r           <= r_n;
      k           <= k_n;
      c           <= c_n;
      bw          <= bw_n;
      bd          <= bd_n;
      weight_addr <= bw_n +
                     ADDR_WIDTH'(r_n) * ADDR_WIDTH'(kt_n) +
                     ADDR_WIDTH'(k_n);
      data_addr   <= bd_n +
                     ADDR_WIDTH'(k_n) * ADDR_WIDTH'(ct_n) +
                     ADDR_WIDTH'(c_n);
      accum_table_submat_row_out <= RW'(r_n);
      accum_table_submat_col_out <= CW'(c_n);
      accum_en    <= (k_n != '0);
    end
  end

  assign weight_mem_fifo_en = (state == W_MEM);
  assign weight_fifo_arr_en = (state == W_ARR);
  assign data_mem_calc_en   = (state == D_CALC);
  assign done               = (state == FINISH);
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_master_tiled_multip_control.sv
// Bench for master_tiled_multip_control: random-latency responders and a
// loop-nest reference model of the expected tile walk.
module tb_master_tiled_multip_control;

  localparam int H  = 16;
  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active = 1'b0;
  logic [7:0]  m_i = '0, k_i = '0, n_i = '0;
  logic [15:0] bw_i = '0, bd_i = '0;
  logic        weight_mem_fifo_done, weight_fifo_arr_done, data_mem_calc_done;
  logic        weight_mem_fifo_en, weight_fifo_arr_en, data_mem_calc_en;
  logic [15:0] weight_addr, data_addr;
  logic [2:0]  row_out, col_out;
  logic        accum_en, busy, done;

  master_tiled_multip_control dut (
    .clk                        (clk),
    .reset                      (reset),
    .active                     (active),
    .num_row_weight_mat         (m_i),
    .intermed_dim               (k_i),
    .num_col_in_mat             (n_i),
    .base_weight                (bw_i),
    .base_data                  (bd_i),
    .weight_mem_fifo_done       (weight_mem_fifo_done),
    .weight_fifo_arr_done       (weight_fifo_arr_done),
    .data_mem_calc_done         (data_mem_calc_done),
    .weight_mem_fifo_en         (weight_mem_fifo_en),
    .weight_fifo_arr_en         (weight_fifo_arr_en),
    .data_mem_calc_en           (data_mem_calc_en),
    .weight_addr                (weight_addr),
    .data_addr                  (data_addr),
    .accum_table_submat_row_out (row_out),
    .accum_table_submat_col_out (col_out),
    .accum_en                   (accum_en),
    .busy                       (busy),
    .done                       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // responders: lat_max==0 echoes enable as done in the same cycle
  int   lat_min = 1, lat_max = 0;
  logic wmf_r = 1'b0, wfa_r = 1'b0, dmc_r = 1'b0, stray = 1'b0;
  int   wmf_cnt = 0, wfa_cnt = 0, dmc_cnt = 0;
  int   wmf_lat = 1, wfa_lat = 1, dmc_lat = 1;

  assign weight_mem_fifo_done = (lat_max == 0) ? weight_mem_fifo_en : wmf_r;
  assign weight_fifo_arr_done = (lat_max == 0) ? weight_fifo_arr_en : wfa_r;
  assign data_mem_calc_done   = ((lat_max == 0) ? data_mem_calc_en : dmc_r)
                                | stray;

  always @(negedge clk) begin
    if (weight_mem_fifo_en && lat_max > 0) begin
      if (wmf_cnt == 0) wmf_lat = $urandom_range(lat_min, lat_max);
      wmf_cnt++;
      wmf_r = (wmf_cnt >= wmf_lat);
    end else begin
      wmf_cnt = 0;
      wmf_r = 1'b0;
    end
    if (weight_fifo_arr_en && lat_max > 0) begin
      if (wfa_cnt == 0) wfa_lat = $urandom_range(lat_min, lat_max);
      wfa_cnt++;
      wfa_r = (wfa_cnt >= wfa_lat);
    end else begin
      wfa_cnt = 0;
      wfa_r = 1'b0;
    end
    if (data_mem_calc_en && lat_max > 0) begin
      if (dmc_cnt == 0) dmc_lat = $urandom_range(lat_min, lat_max);
      dmc_cnt++;
      dmc_r = (dmc_cnt >= dmc_lat);
    end else begin
      dmc_cnt = 0;
      dmc_r = 1'b0;
    end
  end

  typedef struct packed {
    logic [15:0] wa;
    logic [15:0] da;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        acc;
  } tile_t;

  tile_t       got_d[$];
  logic [15:0] got_w[$];
  logic        prev_dmc = 1'b0, prev_wmf = 1'b0;

  always @(negedge clk) begin
    chk("onehot_en",
        32'(($countones({weight_mem_fifo_en, weight_fifo_arr_en,
                         data_mem_calc_en}) <= 1)), 1);
    if (data_mem_calc_en && !prev_dmc)
      got_d.push_back({weight_addr, data_addr, row_out, col_out, accum_en});
    else if (data_mem_calc_en && got_d.size() > 0)
      chk("d_addr_stable", data_addr, got_d[got_d.size()-1].da);
    if (weight_mem_fifo_en && !prev_wmf)
      got_w.push_back(weight_addr);
    prev_dmc = data_mem_calc_en;
    prev_wmf = weight_mem_fifo_en;
  end

  task automatic run_op(input int m, input int kd, input int n,
                        input logic [15:0] bw, input logic [15:0] bd,
                        input int lmin, input int lmax, input bit strayt);
    int rt, kt, ct, cyc, limit, lmx, nmin;
    bit zero, sdone;
    tile_t e;
    tile_t ed[$];
    logic [15:0] ew[$];
    zero = (m == 0) || (kd == 0) || (n == 0);
    rt = (m + H - 1) / H;
    kt = (kd + H - 1) / H;
    ct = (n + WD - 1) / WD;
    lmx = (lmax > 0) ? lmax : 1;
    limit = (2 * rt * kt + 2 * rt * kt * ct) * (lmx + 1) + 20;
    lat_min = lmin;
    lat_max = lmax;
    @(negedge clk);
    got_d.delete();
    got_w.delete();
    m_i = 8'(m);
    k_i = 8'(kd);
    n_i = 8'(n);
    bw_i = bw;
    bd_i = bd;
    active = 1'b1;
    @(posedge clk);
    #1;
    active = 1'b0;
    m_i = 8'($urandom);
    k_i = 8'($urandom);
    n_i = 8'($urandom);
    bw_i = 16'($urandom);
    bd_i = 16'($urandom);
    cyc = 0;
    sdone = 1'b0;
    forever begin
      @(negedge clk);
      if (strayt && !sdone && weight_mem_fifo_en) begin
        active = 1'b1;
        stray = 1'b1;
        sdone = 1'b1;
      end else begin
        active = 1'b0;
        stray = 1'b0;
      end
      if (done === 1'b1 || cyc > limit) break;
      cyc++;
    end
    chk("timeout", 32'(cyc > limit), 0);
    if (strayt) chk("stray_applied", 32'(sdone), 1);
    if (lmax == 0)
      chk("cycles", cyc, zero ? 0 : 2 * rt * kt + 2 * rt * kt * ct);
    chk("busy_in_finish", 32'(busy), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after", 32'(busy), 0);
    if (!zero) begin
      for (int rr = 0; rr < rt; rr++) begin
        for (int kk = 0; kk < kt; kk++) begin
          ew.push_back(16'(int'(bw) + rr * kt + kk));
          for (int cc = 0; cc < ct; cc++) begin
            e.wa  = 16'(int'(bw) + rr * kt + kk);
            e.da  = 16'(int'(bd) + kk * ct + cc);
            e.r   = 3'(rr);
            e.c   = 3'(cc);
            e.acc = (kk != 0);
            ed.push_back(e);
          end
        end
      end
    end
    chk("n_wmem", got_w.size(), ew.size());
    chk("n_tiles", got_d.size(), ed.size());
    nmin = (got_w.size() < ew.size()) ? got_w.size() : ew.size();
    for (int i = 0; i < nmin; i++) chk("wmem_addr", got_w[i], ew[i]);
    nmin = (got_d.size() < ed.size()) ? got_d.size() : ed.size();
    for (int i = 0; i < nmin; i++) begin
      chk("tile_waddr", got_d[i].wa, ed[i].wa);
      chk("tile_daddr", got_d[i].da, ed[i].da);
      chk("tile_row", 32'(got_d[i].r), 32'(ed[i].r));
      chk("tile_col", 32'(got_d[i].c), 32'(ed[i].c));
      chk("tile_accum", 32'(got_d[i].acc), 32'(ed[i].acc));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wmf_en"}, 32'(weight_mem_fifo_en), 0);
    chk({tag, "_wfa_en"}, 32'(weight_fifo_arr_en), 0);
    chk({tag, "_dmc_en"}, 32'(data_mem_calc_en), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_accum"}, 32'(accum_en), 0);
    chk({tag, "_waddr"}, weight_addr, 0);
    chk({tag, "_daddr"}, data_addr, 0);
    chk({tag, "_row"}, 32'(row_out), 0);
    chk({tag, "_col"}, 32'(col_out), 0);
  endtask

  initial begin
    int cyc;
    int m, kd, n;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_active", 32'(busy), 0);

    run_op(16, 16, 16, 16'h0100, 16'h0200, 0, 0, 1'b0);
    run_op(32, 16, 48, 16'h0040, 16'h0800, 0, 0, 1'b0);
    run_op(16, 40, 16, 16'h1000, 16'h2000, 1, 3, 1'b0);
    run_op(16, 16, 0, 16'h0011, 16'h0022, 0, 0, 1'b0);
    run_op(0, 33, 17, 16'h0011, 16'h0022, 1, 2, 1'b0);
    run_op(32, 48, 32, 16'hFFFE, 16'hFFFD, 0, 0, 1'b0);

    // reset in the middle of the second D_CALC with slow responders
    lat_min = 7;
    lat_max = 7;
    @(negedge clk);
    got_d.delete();
    got_w.delete();
    m_i = 8'd16;
    k_i = 8'd16;
    n_i = 8'd48;
    bw_i = 16'h0300;
    bd_i = 16'h0400;
    active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    cyc = 0;
    while (got_d.size() < 2 && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("mid_reached", 32'(got_d.size() >= 2), 1);
    repeat (2) @(negedge clk);
    chk("mid_in_dcalc", 32'(data_mem_calc_en), 1);
    chk("mid_col", 32'(col_out), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'(busy), 0);
    run_op(16, 16, 48, 16'h0300, 16'h0400, 1, 3, 1'b0);

    run_op(32, 32, 32, 16'h0500, 16'h0600, 2, 4, 1'b1);

    for (int i = 0; i < 8; i++) begin
      m  = $urandom_range(1, 80);
      kd = $urandom_range(1, 80);
      n  = $urandom_range(1, 80);
      if (i % 2 == 0)
        run_op(m, kd, n, 16'($urandom), 16'($urandom), 0, 0, 1'b0);
      else
        run_op(m, kd, n, 16'($urandom), 16'($urandom), 1, 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
